iob_aclint: RTL and testbench



---
 rtl/iob_aclint_if.sv | 23 ++
 rtl/iob_aclint.sv | 183 ++++++++++++++++++
 tb/tb_iob_aclint.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/iob_aclint_if.sv
// iob native bus bundle used by the ACLINT block.
// Master drives the request, slave returns rdata/ready one cycle later.
interface iob_aclint_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iob_aclint.sv
// ACLINT timer and software-interrupt block on the iob bus.
// MTIMER (mtime/mtimecmp), MSWI (msip) and SSWI (edge ssip) devices.
module iob_aclint #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int N_CORES     = 1,
    parameter int RTC_MODE    = 0,
    parameter int CLK_DIV     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rt_clk,
    iob_aclint_if.slave        bus,
    output logic [N_CORES-1:0] mtip,
    output logic [N_CORES-1:0] msip,
    output logic [N_CORES-1:0] ssip
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(32'hBFFC);

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    logic [DATA_W-1:0]   wd;
    logic [DATA_W/8-1:0] ws;
    logic                wr;
    logic                rd;

    assign wd = bus.wdata;
    assign ws = bus.wstrb;
    assign wr = bus.valid & (|bus.wstrb);
    assign rd = bus.valid & ~(|bus.wstrb);

    logic [N_CORES-1:0] msip_hit;
    logic [N_CORES-1:0] cmpl_hit;
    logic [N_CORES-1:0] cmph_hit;
    logic [N_CORES-1:0] ssip_hit;
    logic               mtl_hit;
    logic               mth_hit;

    // Exact full-width matches only, so no region aliases into another.
    always_comb begin
        msip_hit = '0;
        cmpl_hit = '0;
        cmph_hit = '0;
        ssip_hit = '0;
        for (int k = 0; k < N_CORES; k++) begin
            msip_hit[k] = bus.address == ADDR_W'(32'h0000 + 4*k);
            cmpl_hit[k] = bus.address == ADDR_W'(32'h4000 + 8*k);
            cmph_hit[k] = bus.address == ADDR_W'(32'h4004 + 8*k);
            ssip_hit[k] = bus.address == ADDR_W'(32'hC000 + 4*k);
        end
    end

    assign mtl_hit = bus.address == MTIME_LO;
    assign mth_hit = bus.address == MTIME_HI;

    logic [PW-1:0]          presc;
    logic                   div_tick;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rt_prev;
    logic                   rt_tick;
    logic                   tick;

    assign div_tick = presc == PW'(CLK_DIV - 1);
    assign rt_tick  = sync[SYNC_STAGES-1] & ~rt_prev;
    assign tick     = (RTC_MODE != 0) ? rt_tick : div_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            sync    <= '0;
            rt_prev <= 1'b0;
        end else begin
            presc   <= div_tick ? '0 : presc + PW'(1);
            sync    <= {sync[SYNC_STAGES-2:0], rt_clk};
            rt_prev <= sync[SYNC_STAGES-1];
        end
    end

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [31:0] shadow;
    logic [63:0] mtimecmp [N_CORES];

    // A bus write to either mtime half suppresses that cycle's increment.
    always_comb begin
        mtime_nxt = mtime;
        if (wr && mtl_hit)
            mtime_nxt[31:0] = merge(mtime[31:0], wd, ws);
        else if (wr && mth_hit)
            mtime_nxt[63:32] = merge(mtime[63:32], wd, ws);
        else if (tick)
            mtime_nxt = mtime + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime  <= '0;
            shadow <= '0;
        end else begin
            mtime <= mtime_nxt;
            if (rd && mtl_hit)
                shadow <= mtime[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CORES; k++)
                mtimecmp[k] <= '1;
        end else begin
            for (int k = 0; k < N_CORES; k++) begin
                if (wr && cmpl_hit[k])
                    mtimecmp[k][31:0] <=
                        merge(mtimecmp[k][31:0], wd, ws);
                if (wr && cmph_hit[k])
                    mtimecmp[k][63:32] <=
                        merge(mtimecmp[k][63:32], wd, ws);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip <= '0;
            msip <= '0;
            ssip <= '0;
        end else begin
            for (int k = 0; k < N_CORES; k++) begin
                mtip[k] <= mtime >= mtimecmp[k];
                if (wr && msip_hit[k] && ws[0])
                    msip[k] <= wd[0];
                ssip[k] <= wr & ssip_hit[k] & ws[0] & wd[0];
            end
        end
    end

    logic [DATA_W-1:0] rmux;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;

    always_comb begin
        rmux = '0;
        if (mtl_hit) rmux = mtime[31:0];
        if (mth_hit) rmux = shadow;
        for (int k = 0; k < N_CORES; k++) begin
            if (msip_hit[k])
                rmux = {{(DATA_W-1){1'b0}}, msip[k]};
            if (cmpl_hit[k])
                rmux = mtimecmp[k][31:0];
            if (cmph_hit[k])
                rmux = mtimecmp[k][63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            rdata_q <= rd ? rmux : '0;
            ready_q <= bus.valid;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_iob_aclint.sv
// Directed bench: prescaled instance (2 harts) and rt_clk instance.
module tb_iob_aclint;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rt0 = 1'b0;
    logic rt1 = 1'b0;

    logic [1:0] mtip0, msip0, ssip0;
    logic [0:0] mtip1, msip1, ssip1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    iob_aclint_if #(.ADDR_W(16), .DATA_W(32)) b0 ();
    iob_aclint_if #(.ADDR_W(16), .DATA_W(32)) b1 ();

    iob_aclint #(
        .ADDR_W(16), .DATA_W(32), .N_CORES(2),
        .RTC_MODE(0), .CLK_DIV(4), .SYNC_STAGES(2)
    ) u0 (
        .clk(clk), .rst(rst), .rt_clk(rt0), .bus(b0),
        .mtip(mtip0), .msip(msip0), .ssip(ssip0)
    );

    iob_aclint #(
        .ADDR_W(16), .DATA_W(32), .N_CORES(1),
        .RTC_MODE(1), .CLK_DIV(4), .SYNC_STAGES(2)
    ) u1 (
        .clk(clk), .rst(rst), .rt_clk(rt1), .bus(b1),
        .mtip(mtip1), .msip(msip1), .ssip(ssip1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.valid = 1'b0; b0.wstrb = '0;
        b1.valid = 1'b0; b1.wstrb = '0;
    endtask

    task automatic wr(int u, logic [15:0] a, logic [31:0] d,
                      logic [3:0] s);
        if (u == 0) begin
            b0.valid = 1'b1; b0.address = a;
            b0.wdata = d;    b0.wstrb = s;
        end else begin
            b1.valid = 1'b1; b1.address = a;
            b1.wdata = d;    b1.wstrb = s;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic rd(int u, logic [15:0] a, output logic [31:0] d);
        logic r;
        if (u == 0) begin
            b0.valid = 1'b1; b0.address = a; b0.wstrb = '0;
        end else begin
            b1.valid = 1'b1; b1.address = a; b1.wstrb = '0;
        end
        @(negedge clk);
        d = (u == 0) ? b0.rdata : b1.rdata;
        r = (u == 0) ? b0.ready : b1.ready;
        chk("ready", 32'(r), 32'd1);
        idle();
    endtask

    initial begin
        logic [31:0] v;
        int n;
        b0.address = '0; b0.wdata = '0;
        b1.address = '0; b1.wdata = '0;
        idle();
        repeat (3) @(negedge clk);

        chk("rst_rdata", b0.rdata, 32'h0);
        chk("rst_ready", 32'(b0.ready), 32'h0);
        chk("rst_irq", {26'h0, mtip0, msip0, ssip0}, 32'h0);
        rst = 1'b0;

        repeat (40) @(negedge clk);
        rd(0, 16'hBFF8, v);
        chk("mtime40", v, 32'd10);
        chk("mtip_idle", 32'(mtip0), 32'h0);
        rd(0, 16'h4004, v);
        chk("cmp_rst", v, 32'hFFFF_FFFF);

        wr(0, 16'h4000, 32'h14, 4'hF);
        wr(0, 16'h4004, 32'h0, 4'hF);
        n = 0;
        while (mtip0[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mtip_rise_cyc", 32'(cyc), 32'd81);
        wr(0, 16'h4000, 32'hFFFF_FFFF, 4'hF);
        chk("mtip_hold", 32'(mtip0[0]), 32'h1);
        @(negedge clk);
        chk("mtip_clr", 32'(mtip0[0]), 32'h0);
        rd(0, 16'h4008, v);
        chk("cmp1_lo", v, 32'hFFFF_FFFF);
        rd(0, 16'h4010, v);
        chk("cmp2_none", v, 32'h0);

        while (cyc % 4 != 0) @(negedge clk);
        wr(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        wr(0, 16'hBFFC, 32'h1, 4'hF);
        rd(0, 16'hBFF8, v);
        chk("coh_lo0", v, 32'hFFFF_FFFE);
        repeat (6) @(negedge clk);
        rd(0, 16'hBFFC, v);
        chk("coh_hi_shadow", v, 32'h1);
        rd(0, 16'hBFF8, v);
        chk("coh_lo_wrap", v, 32'h0);
        rd(0, 16'hBFFC, v);
        chk("coh_hi_new", v, 32'h2);

        while (cyc % 4 != 0) @(negedge clk);
        wr(0, 16'hBFF8, 32'h1234_5600, 4'hF);
        wr(0, 16'hBFFC, 32'h0, 4'hF);
        @(negedge clk);
        wr(0, 16'hBFF8, 32'hFFFF_FFAA, 4'b0001);
        rd(0, 16'hBFF8, v);
        chk("strb_lo", v, 32'h1234_56AA);
        rd(0, 16'hBFFC, v);
        chk("strb_hi", v, 32'h0);

        wr(0, 16'h0004, 32'h1, 4'hF);
        chk("msip1_set", 32'(msip0), 32'h2);
        wr(0, 16'h0004, 32'h0, 4'b0010);
        chk("msip_strb", 32'(msip0), 32'h2);
        wr(0, 16'hC000, 32'h1, 4'hF);
        chk("ssip_pulse", 32'(ssip0), 32'h1);
        @(negedge clk);
        chk("ssip_end", 32'(ssip0), 32'h0);
        wr(0, 16'hC000, 32'h0, 4'hF);
        chk("ssip_zero", 32'(ssip0), 32'h0);
        rd(0, 16'hC000, v);
        chk("ssip_rd", v, 32'h0);
        wr(0, 16'h0008, 32'h1, 4'hF);
        chk("msip_oob", 32'(msip0), 32'h2);
        rd(0, 16'h0008, v);
        chk("oob_rd", v, 32'h0);
        rd(0, 16'h0004, v);
        chk("msip1_rd", v, 32'h1);

        for (int p = 0; p < 10; p++) begin
            rt1 = 1'b1;
            @(negedge clk);
            rt1 = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        rd(1, 16'hBFF8, v);
        chk("rtc_mtime", v, 32'd10);
        chk("rtc_mtip", 32'(mtip1), 32'h0);

        b1.valid = 1'b1; b1.address = 16'hBFF8; b1.wstrb = '0;
        @(posedge clk);
        #1;
        chk("inflight_ready", 32'(b1.ready), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(b1.ready), 32'h0);
        chk("rst_mid_rdata", b1.rdata, 32'h0);
        chk("rst_mid_irq", {29'h0, mtip0[0], msip0}, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b0;
        rd(1, 16'hBFF8, v);
        chk("rst_mtime1", v, 32'h0);
        rd(0, 16'hBFF8, v);
        chk("rst_mtime0", v, 32'h0);
        rd(0, 16'h4004, v);
        chk("rst_cmp_hi", v, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
